// File: rtl/bcd_sum_ctrl.sv
// ---------------------------------------------------------------------------
// bcd_sum_ctrl
//
// Purpose:
//   Sequencing controller for the adder-to-decimal display path. Two 4-bit
//   operands plus carry-in arrive over a valid/ready handshake. The controller
//   forms the 5-bit binary sum (0..31) and converts it to two BCD digits with
//   a shift-add-3 (double-dabble) engine that does one shift per clock. The
//   result is offered over a valid/ack handshake. The held digits are also
//   time-multiplexed onto a single digit bus for the seven-segment decoder.
//
// Parameters:
//   REFRESH_DIV  clock cycles each digit is shown before digit_sel toggles (>=1)
//   BLANK_LZ     1 = blank the tens digit when it is zero
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   start_valid   operands a/b/cin are valid
//   start_ready   controller can accept operands (high only in IDLE)
//   a, b          4-bit unsigned operands
//   cin           carry-in
//   busy          conversion in progress (ADD and CONV)
//   result_valid  tens/ones hold a new result, held until result_ack
//   result_ack    consumer accepts the result
//   tens, ones    BCD result digits, updated only when a conversion completes
//   digit_sel     0 = ones digit shown, 1 = tens digit shown
//   digit_out     BCD digit currently shown
//   blank         1 = the display for digit_sel is blanked
// ---------------------------------------------------------------------------
module bcd_sum_ctrl #(
  parameter int REFRESH_DIV = 4,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_valid,
  output logic       start_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic       busy,
  output logic       result_valid,
  input  logic       result_ack,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       digit_sel,
  output logic [3:0] digit_out,
  output logic       blank
);

  // Refresh counter width; at least one bit so REFRESH_DIV = 1 still works.
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] REFRESH_MAX = CW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    CONV = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    a_q;
  logic [3:0]    b_q;
  logic          cin_q;
  logic [12:0]   shift_q;
  logic [2:0]    iter_q;
  logic [3:0]    tens_q;
  logic [3:0]    ones_q;
  logic          start_ready_q;
  logic          busy_q;
  logic          result_valid_q;
  logic          digit_sel_q;
  logic [CW-1:0] refresh_q;

  logic [4:0]    sum_d;
  logic [12:0]   adj_d;
  logic [12:0]   shift_d;

  // Operand sum is formed at 5 bits so 15+15+1 = 31 is never truncated.
  // The double-dabble step corrects each BCD nibble that is 5 or more by
  // adding 3, so that the following left shift carries correctly into the
  // next decimal digit. The shift register layout is {tens, ones, bin[4:0]}.
  always_comb begin
    sum_d = {1'b0, a_q} + {1'b0, b_q} + {4'd0, cin_q};
    adj_d = shift_q;
    if (shift_q[12:9] >= 4'd5) begin
      adj_d[12:9] = shift_q[12:9] + 4'd3;
    end
    if (shift_q[8:5] >= 4'd5) begin
      adj_d[8:5] = shift_q[8:5] + 4'd3;
    end
    shift_d = {adj_d[11:0], 1'b0};
  end

  // Main controller. All handshake outputs are registered and change together
  // with the state. tens/ones are loaded only on the edge that performs the
  // fifth shift, so the display never shows a partial conversion and keeps
  // the previous result while a new job is running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      a_q            <= 4'd0;
      b_q            <= 4'd0;
      cin_q          <= 1'b0;
      shift_q        <= 13'd0;
      iter_q         <= 3'd0;
      tens_q         <= 4'd0;
      ones_q         <= 4'd0;
      start_ready_q  <= 1'b1;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_valid) begin
            a_q           <= a;
            b_q           <= b;
            cin_q         <= cin;
            start_ready_q <= 1'b0;
            busy_q        <= 1'b1;
            state_q       <= ADD;
          end
        end
        ADD: begin
          shift_q <= {8'd0, sum_d};
          iter_q  <= 3'd5;
          state_q <= CONV;
        end
        CONV: begin
          shift_q <= shift_d;
          iter_q  <= iter_q - 3'd1;
          if (iter_q == 3'd1) begin
            tens_q         <= shift_d[12:9];
            ones_q         <= shift_d[8:5];
            busy_q         <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          // A start request arriving together with the ack is dropped:
          // start_ready is still low on this edge.
          if (result_ack) begin
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: begin
          state_q        <= IDLE;
          start_ready_q  <= 1'b1;
          busy_q         <= 1'b0;
          result_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Display refresh runs every cycle regardless of controller state. Each
  // wrap of the counter hands the display over to the other digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      refresh_q   <= '0;
      digit_sel_q <= 1'b0;
    end else if (refresh_q == REFRESH_MAX) begin
      refresh_q   <= '0;
      digit_sel_q <= ~digit_sel_q;
    end else begin
      refresh_q <= refresh_q + 1'b1;
    end
  end

  assign start_ready  = start_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign tens         = tens_q;
  assign ones         = ones_q;
  assign digit_sel    = digit_sel_q;

  // Only the tens digit can be blanked; a zero ones digit is always shown.
  assign digit_out = digit_sel_q ? tens_q : ones_q;
  assign blank     = BLANK_LZ & digit_sel_q & (tens_q == 4'd0);

endmodule

// File: tb/tb_bcd_sum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bcd_sum_ctrl
//
// Directed bench for bcd_sum_ctrl. A second instance with BLANK_LZ = 0 shares
// all inputs so the leading-zero blanking can be compared against a display
// that never blanks. Inputs change and outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.
// ---------------------------------------------------------------------------
module tb_bcd_sum_ctrl;

  logic       clk;
  logic       reset;
  logic       start_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic       result_ack;

  logic       start_ready;
  logic       busy;
  logic       result_valid;
  logic [3:0] tens;
  logic [3:0] ones;
  logic       digit_sel;
  logic [3:0] digit_out;
  logic       blank;

  logic       start_ready2;
  logic       busy2;
  logic       result_valid2;
  logic [3:0] tens2;
  logic [3:0] ones2;
  logic       digit_sel2;
  logic [3:0] digit_out2;
  logic       blank2;

  int errors = 0;
  int checks = 0;

  bcd_sum_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin), .busy(busy), .result_valid(result_valid),
    .result_ack(result_ack), .tens(tens), .ones(ones), .digit_sel(digit_sel),
    .digit_out(digit_out), .blank(blank)
  );

  bcd_sum_ctrl #(.REFRESH_DIV(4), .BLANK_LZ(1'b0)) dut_nolz (
    .clk(clk), .reset(reset), .start_valid(start_valid), .start_ready(start_ready2),
    .a(a), .b(b), .cin(cin), .busy(busy2), .result_valid(result_valid2),
    .result_ack(result_ack), .tens(tens2), .ones(ones2), .digit_sel(digit_sel2),
    .digit_out(digit_out2), .blank(blank2)
  );

  // 100 MHz-style clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // Presents operands for exactly one rising edge; returns on the falling
  // edge after that acceptance edge.
  task automatic applyStimulus(input logic [3:0] va, input logic [3:0] vb,
                               input logic vc);
    a           = va;
    b           = vb;
    cin         = vc;
    start_valid = 1'b1;
    tick(1);
    start_valid = 1'b0;
  endtask

  // Waits a bounded number of cycles for result_valid; an expired bound is
  // recorded as a failed check.
  task automatic waitResult(input string tag);
    int n = 0;
    while (result_valid !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    checkOutput(tag, {7'd0, result_valid}, 8'd1);
  endtask

  task automatic ackResult();
    result_ack = 1'b1;
    tick(1);
    result_ack = 1'b0;
  endtask

  task automatic runJob(input logic [3:0] va, input logic [3:0] vb, input logic vc,
                        input logic [3:0] expT, input logic [3:0] expO,
                        input string tag);
    applyStimulus(va, vb, vc);
    waitResult({tag, "_valid"});
    checkOutput({tag, "_tens"}, {4'd0, tens}, {4'd0, expT});
    checkOutput({tag, "_ones"}, {4'd0, ones}, {4'd0, expO});
    ackResult();
  endtask

  // Locks onto a digit_sel toggle, then follows two full display periods
  // with a bench-side phase tracker.
  task automatic trackDisplay(input logic [3:0] expT, input logic [3:0] expO,
                              input string tag);
    logic s0;
    logic expSel;
    int   n;
    s0 = digit_sel;
    n  = 0;
    while (digit_sel === s0 && n < 8) begin
      tick(1);
      n++;
    end
    expSel = ~s0;
    for (int k = 0; k < 16; k++) begin
      if (k > 0 && (k % 4) == 0) expSel = ~expSel;
      checkOutput({tag, "_sel"}, {7'd0, digit_sel}, {7'd0, expSel});
      checkOutput({tag, "_digit"}, {4'd0, digit_out}, {4'd0, expSel ? expT : expO});
      checkOutput({tag, "_blank"}, {7'd0, blank},
                  {7'd0, expSel & (expT == 4'd0)});
      checkOutput({tag, "_blank_nolz"}, {7'd0, blank2}, 8'd0);
      tick(1);
    end
  endtask

  initial begin
    int sum;
    reset       = 1'b1;
    start_valid = 1'b0;
    result_ack  = 1'b0;
    a           = 4'd0;
    b           = 4'd0;
    cin         = 1'b0;

    // Reset values.
    tick(2);
    checkOutput("rst_ready", {7'd0, start_ready}, 8'd1);
    checkOutput("rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("rst_valid", {7'd0, result_valid}, 8'd0);
    checkOutput("rst_tens", {4'd0, tens}, 8'd0);
    checkOutput("rst_ones", {4'd0, ones}, 8'd0);
    checkOutput("rst_sel", {7'd0, digit_sel}, 8'd0);
    reset = 1'b0;
    tick(1);

    // 9+8+1 = 18: busy for six cycles, result six cycles after acceptance.
    applyStimulus(4'd9, 4'd8, 1'b1);
    checkOutput("t1_ready_low", {7'd0, start_ready}, 8'd0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t1_busy", {7'd0, busy}, 8'd1);
      checkOutput("t1_not_valid", {7'd0, result_valid}, 8'd0);
      tick(1);
    end
    checkOutput("t1_valid", {7'd0, result_valid}, 8'd1);
    checkOutput("t1_busy_done", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t1_hold_valid", {7'd0, result_valid}, 8'd1);
      checkOutput("t1_hold_tens", {4'd0, tens}, 8'd1);
      checkOutput("t1_hold_ones", {4'd0, ones}, 8'd8);
      tick(1);
    end
    ackResult();
    checkOutput("t1_ack_valid", {7'd0, result_valid}, 8'd0);
    checkOutput("t1_ack_ready", {7'd0, start_ready}, 8'd1);

    // Boundary sums.
    runJob(4'd15, 4'd15, 1'b1, 4'd3, 4'd1, "t2_max");
    runJob(4'd0, 4'd0, 1'b0, 4'd0, 4'd0, "t2_zero");
    runJob(4'd5, 4'd4, 1'b0, 4'd0, 4'd9, "t2_nine");
    runJob(4'd5, 4'd4, 1'b1, 4'd1, 4'd0, "t2_ten");

    // Start during CONV of 7+7 is ignored and never queued.
    applyStimulus(4'd7, 4'd7, 1'b0);
    tick(2);
    applyStimulus(4'd3, 4'd3, 1'b0);
    waitResult("t3_valid");
    checkOutput("t3_tens", {4'd0, tens}, 8'd1);
    checkOutput("t3_ones", {4'd0, ones}, 8'd4);
    // Start and ack together in DONE: ack wins, start is dropped.
    a           = 4'd2;
    b           = 4'd2;
    start_valid = 1'b1;
    result_ack  = 1'b1;
    tick(1);
    start_valid = 1'b0;
    result_ack  = 1'b0;
    checkOutput("t3_simul_valid", {7'd0, result_valid}, 8'd0);
    checkOutput("t3_simul_ready", {7'd0, start_ready}, 8'd1);
    checkOutput("t3_simul_busy", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 10; i++) begin
      checkOutput("t3_no_second", {7'd0, result_valid}, 8'd0);
      checkOutput("t3_idle_busy", {7'd0, busy}, 8'd0);
      tick(1);
    end
    // Ack in IDLE has no effect.
    ackResult();
    checkOutput("t3_idle_ack_ready", {7'd0, start_ready}, 8'd1);
    checkOutput("t3_idle_ack_valid", {7'd0, result_valid}, 8'd0);
    checkOutput("t3_idle_ack_tens", {4'd0, tens}, 8'd1);

    // Reset in the third CONV cycle of 9+9+0.
    applyStimulus(4'd9, 4'd9, 1'b0);
    tick(3);
    checkOutput("t4_in_conv", {7'd0, busy}, 8'd1);
    reset = 1'b1;
    #1;
    checkOutput("t4_rst_ready", {7'd0, start_ready}, 8'd1);
    checkOutput("t4_rst_busy", {7'd0, busy}, 8'd0);
    checkOutput("t4_rst_valid", {7'd0, result_valid}, 8'd0);
    checkOutput("t4_rst_tens", {4'd0, tens}, 8'd0);
    checkOutput("t4_rst_ones", {4'd0, ones}, 8'd0);
    checkOutput("t4_rst_sel", {7'd0, digit_sel}, 8'd0);
    tick(1);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      checkOutput("t4_no_result", {7'd0, result_valid}, 8'd0);
      tick(1);
    end
    runJob(4'd2, 4'd2, 1'b0, 4'd0, 4'd4, "t4_after");

    // Display multiplexing and leading-zero blanking.
    runJob(4'd1, 4'd9, 1'b1, 4'd1, 4'd1, "t5_eleven");
    trackDisplay(4'd1, 4'd1, "t5_disp11");
    runJob(4'd2, 4'd3, 1'b0, 4'd0, 4'd5, "t5_five");
    trackDisplay(4'd0, 4'd5, "t5_disp05");

    // tens/ones hold through a new job until the DONE-entry edge.
    runJob(4'd9, 4'd8, 1'b1, 4'd1, 4'd8, "t6_first");
    applyStimulus(4'd0, 4'd0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checkOutput("t6_hold_tens", {4'd0, tens}, 8'd1);
      checkOutput("t6_hold_ones", {4'd0, ones}, 8'd8);
      tick(1);
    end
    checkOutput("t6_new_valid", {7'd0, result_valid}, 8'd1);
    checkOutput("t6_new_tens", {4'd0, tens}, 8'd0);
    checkOutput("t6_new_ones", {4'd0, ones}, 8'd0);
    ackResult();

    // Full operand sweep against decimal arithmetic.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          sum = ia + ib + ic;
          runJob(4'(ia), 4'(ib), 1'(ic), 4'(sum / 10), 4'(sum % 10), "sweep");
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_sum_ctrl.md
Name: bcd_sum_ctrl

Overview:
Sequencing controller for the lab adder-to-decimal display path. It accepts two 4-bit operands plus carry-in over a valid/ready handshake and forms the 5-bit binary sum (0..31). It converts the sum to two BCD digits with an iterative shift-add-3 (double-dabble) engine, one shift per clock, and presents the result over a valid/ack handshake. It also time-multiplexes the held tens/ones digits onto a single digit bus for the board's seven-segment decoder.

Parameters:
REFRESH_DIV, 4, clock cycles each digit is shown before digit_sel toggles (>=1)
BLANK_LZ, 1, 1 = blank the tens digit when it is 0

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start_valid  input  1  operands a/b/cin are valid
start_ready  output  1  controller can accept operands
a  input  4  operand A, unsigned binary
b  input  4  operand B, unsigned binary
cin  input  1  carry-in
busy  output  1  conversion in progress
result_valid  output  1  tens/ones hold a new result
result_ack  input  1  consumer accepts the result
tens  output  4  BCD tens digit (0..3)
ones  output  4  BCD ones digit (0..9)
digit_sel  output  1  0 = ones digit shown, 1 = tens digit shown
digit_out  output  4  BCD digit currently shown
blank  output  1  1 = the display for digit_sel is blanked

Behaviour:
- One clock domain. Reset is asynchronous and active-high; all registers reset immediately on assertion.
- Reset values:
  - state = IDLE
  - start_ready = 1, busy = 0, result_valid = 0
  - tens = 0, ones = 0
  - digit_sel = 0, refresh counter = 0
  - shift register = 0, iteration counter = 0
- States: IDLE, ADD, CONV, DONE.
- IDLE:
  - start_ready = 1.
  - On an edge with start_valid=1, capture a, b and cin, then go to ADD.
  - Inputs are ignored after capture.
- ADD (1 cycle):
  - Load the 13-bit shift register {tens_acc[3:0], ones_acc[3:0], bin[4:0]} with {0, 0, a+b+cin}.
  - The sum is computed at 5 bits and never truncated.
  - Set iteration counter = 5; go to CONV.
- CONV (exactly 5 cycles): on each edge:
  - Add 3 to any BCD nibble that is >= 5.
  - Then shift the whole register left by 1 and decrement the counter.
  - On the edge that performs the 5th shift, load tens/ones from the nibbles, go to DONE and set result_valid = 1.
- busy = 1 in ADD and CONV; start_ready = 0 outside IDLE. start_valid in those states is ignored and never queued.
- Latency: the acceptance edge is E0. result_valid is first high after E6, i.e. 6 cycles.
- DONE:
  - result_valid holds at 1 until an edge with result_ack=1.
  - On that edge: result_valid = 0, go to IDLE. The earliest next acceptance is the following edge.
  - result_ack outside DONE has no effect.
- tens/ones:
  - Change only on the DONE-entry edge (and on reset).
  - Hold their value through later operations until the next completion, so the display never shows partial conversions.
- Display:
  - The refresh counter counts 0..REFRESH_DIV-1 every cycle, independent of state.
  - On wrap (count = REFRESH_DIV-1 -> 0), digit_sel toggles.
  - digit_out = digit_sel ? tens : ones, combinational.
  - blank = BLANK_LZ & digit_sel & (tens == 0), combinational. The ones digit is never blanked.
- Reset asserted mid-operation (ADD/CONV/DONE):
  - Aborts the operation; no result is produced.
  - Outputs return to their reset values, and display restarts on ones.
- Simultaneous start_valid and result_ack in DONE: ack is honoured, start is ignored (start_ready = 0).

Test Plan:
1. Reset, then a=9, b=8, cin=1 with start_valid=1 for one edge -> busy for 6 cycles; result_valid rises 6 cycles after acceptance; tens=1, ones=8; hold with result_ack=0 for 10 cycles -> values stable; ack -> back to IDLE, start_ready=1 next cycle.
2. Boundary sums:
   - a=15, b=15, cin=1 -> tens=3, ones=1.
   - a=0, b=0, cin=0 -> tens=0, ones=0.
   - a=5, b=4, cin=0 -> tens=0, ones=9.
   - a=5, b=4, cin=1 -> tens=1, ones=0.
   - Bench also sweeps all 512 operand combinations against a reference model.
3. Busy and ack handling:
   - Pulse start_valid with a=3, b=3 during CONV of an earlier 7+7 job -> ignored; result tens=1, ones=4 only; no second result_valid.
   - result_ack pulsed in IDLE -> no effect.
4. Reset: assert reset for 1 cycle in the 3rd CONV cycle of 9+9+0 -> all outputs at reset values immediately; no result_valid; a following 2+2 job yields tens=0, ones=4.
5. Display (REFRESH_DIV=4, BLANK_LZ=1):
   - After 1+9+1 (tens=1, ones=1), digit_sel toggles every 4 cycles; digit_out alternates 1,1; blank=0.
   - After 2+3+0, blank=1 whenever digit_sel=1.
   - With BLANK_LZ=0, blank stays 0.
6. tens/ones hold during a new job: after 9+8+1 (tens=1, ones=8), start 0+0+0 -> tens/ones remain 1/8 through ADD/CONV and change to 0/0 exactly on the DONE-entry edge.
